mem_arbiter: RTL and testbench

Two-requester arbiter that shares one read/write port of `dual_port_distributed_ram` between two masters in the RISC-V CPU, such as the core's load/store unit (requester 0) and a debug/loader or DMA master (requester 1). It grants the RAM port once per cycle with round-robin fairness. It supports locked bursts of bounded length. It registers read data so each requester sees a fixed 1-cycle read latency.

---
 rtl/mem_arbiter.sv | 190 +++++++++++++++++++
 tb/tb_mem_arbiter.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// mem_arbiter
//   Shares one read/write port of dual_port_distributed_ram between two
//   masters (requester 0: load/store unit, requester 1: debug/DMA master).
//   One access is granted per cycle with round-robin fairness. Locked bursts
//   keep ownership for up to MAX_BURST beats while the other side waits.
//   Read data is registered, giving each requester a fixed 1-cycle latency.
//
// Parameters
//   W          data width (matches the RAM)
//   L          RAM depth in words; address width is $clog2(L)
//   MAX_BURST  max consecutive locked beats while the other side waits (>=1)
//
// Ports
//   clk, rst                      clock, synchronous active-high reset
//   reqN, lockN, weN              request, burst lock, write enable
//   addrN, wdataN                 word address, write data
//   gntN                          combinational grant; accepted when reqN & gntN
//   rvalidN, rdataN               registered read response (1-cycle pulse)
//   ram_wr_ena, ram_addr,
//   ram_wr_data, ram_rd_data      RAM port connection (read is asynchronous)
//   stall_count                   only with MEM_ARBITER_STATS_EN defined:
//                                 saturating count of cycles with a stalled
//                                 request
//
// Optional feature macro: MEM_ARBITER_STATS_EN
module mem_arbiter #(
  parameter int W         = 32,
  parameter int L         = 128,
  parameter int MAX_BURST = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req0,
  input  logic                  req1,
  input  logic                  lock0,
  input  logic                  lock1,
  input  logic                  we0,
  input  logic                  we1,
  input  logic [$clog2(L)-1:0]  addr0,
  input  logic [$clog2(L)-1:0]  addr1,
  input  logic [W-1:0]          wdata0,
  input  logic [W-1:0]          wdata1,
  output logic                  gnt0,
  output logic                  gnt1,
  output logic                  rvalid0,
  output logic                  rvalid1,
  output logic [W-1:0]          rdata0,
  output logic [W-1:0]          rdata1,
  output logic                  ram_wr_ena,
  output logic [$clog2(L)-1:0]  ram_addr,
  output logic [W-1:0]          ram_wr_data,
  input  logic [W-1:0]          ram_rd_data
`ifdef MEM_ARBITER_STATS_EN
  ,
  output logic [31:0]           stall_count
`endif
);

  localparam int CW = $clog2(MAX_BURST + 1);
  localparam logic [CW-1:0] MAX_CNT = CW'(MAX_BURST);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OWN0 = 2'd1,
    OWN1 = 2'd2
  } state_t;

  state_t          state_p1;
  state_t          state_d;
  logic            ptr_p1;
  logic            ptr_d;
  logic [CW-1:0]   cnt_p1;
  logic [CW-1:0]   cnt_d;

  logic            hold0_p0;
  logic            hold1_p0;
  logic            sel_vld_p0;
  logic            sel_p0;
  logic            lock_g_p0;
  state_t          own_g_p0;
  logic            rd_acc0_p0;
  logic            rd_acc1_p0;

  // Burst counter increment, saturating at MAX_BURST.
  function automatic logic [CW-1:0] cnt_sat_inc(input logic [CW-1:0] c);
    if (c >= MAX_CNT) begin
      return MAX_CNT;
    end
    return c + CW'(1);
  endfunction

  // ---- stage p0: combinational arbitration and RAM port selection ----
  always_comb begin
    hold0_p0   = (state_p1 == OWN0) && req0 && ((cnt_p1 < MAX_CNT) || !req1);
    hold1_p0   = (state_p1 == OWN1) && req1 && ((cnt_p1 < MAX_CNT) || !req0);
    sel_vld_p0 = 1'b0;
    sel_p0     = 1'b0;
    if (hold0_p0) begin
      sel_vld_p0 = 1'b1;
      sel_p0     = 1'b0;
    end else if (hold1_p0) begin
      sel_vld_p0 = 1'b1;
      sel_p0     = 1'b1;
    end else if (req0 && req1) begin
      // Also covers forced release: the owner lost hold, ptr points away.
      sel_vld_p0 = 1'b1;
      sel_p0     = ptr_p1;
    end else if (req0) begin
      sel_vld_p0 = 1'b1;
      sel_p0     = 1'b0;
    end else if (req1) begin
      sel_vld_p0 = 1'b1;
      sel_p0     = 1'b1;
    end
    // No access is accepted while reset is asserted.
    if (rst) begin
      sel_vld_p0 = 1'b0;
    end
  end

  assign gnt0        = sel_vld_p0 && !sel_p0;
  assign gnt1        = sel_vld_p0 && sel_p0;
  assign ram_addr    = gnt1 ? addr1 : addr0;
  assign ram_wr_data = gnt1 ? wdata1 : wdata0;
  assign ram_wr_ena  = (gnt0 && we0) || (gnt1 && we1);
  assign rd_acc0_p0  = gnt0 && !we0;
  assign rd_acc1_p0  = gnt1 && !we1;
  assign lock_g_p0   = sel_p0 ? lock1 : lock0;
  assign own_g_p0    = sel_p0 ? OWN1 : OWN0;

  always_comb begin
    state_d = IDLE;
    ptr_d   = ptr_p1;
    cnt_d   = '0;
    if (sel_vld_p0) begin
      ptr_d = ~sel_p0;
      if (lock_g_p0) begin
        state_d = own_g_p0;
        cnt_d   = (state_p1 == own_g_p0) ? cnt_sat_inc(cnt_p1) : CW'(1);
      end
    end
  end

  // ---- stage p1: arbitration state register ----
  always_ff @(posedge clk) begin
    if (rst) begin
      state_p1 <= IDLE;
      ptr_p1   <= 1'b0;
      cnt_p1   <= '0;
    end else begin
      state_p1 <= state_d;
      ptr_p1   <= ptr_d;
      cnt_p1   <= cnt_d;
    end
  end

  // ---- stage p1: registered read response ----
  always_ff @(posedge clk) begin
    if (rst) begin
      rvalid0 <= 1'b0;
      rvalid1 <= 1'b0;
      rdata0  <= '0;
      rdata1  <= '0;
    end else begin
      rvalid0 <= rd_acc0_p0;
      rvalid1 <= rd_acc1_p0;
      if (rd_acc0_p0) begin
        rdata0 <= ram_rd_data;
      end
      if (rd_acc1_p0) begin
        rdata1 <= ram_rd_data;
      end
    end
  end

`ifdef MEM_ARBITER_STATS_EN
  logic stall_p0;
  assign stall_p0 = (req0 && !gnt0) || (req1 && !gnt1);

  // ---- stage p1: stall statistics ----
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_count <= '0;
    end else if (stall_p0 && (stall_count != 32'hFFFF_FFFF)) begin
      stall_count <= stall_count + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed testbench for mem_arbiter with a RAM model and a read-data
// scoreboard. Build with MEM_ARBITER_STATS_EN to include the stall counter.
module tb_mem_arbiter;

  localparam int W  = 32;
  localparam int L  = 128;
  localparam int AW = $clog2(L);

  logic          clk = 1'b0;
  logic          rst;
  logic          req0, req1, lock0, lock1, we0, we1;
  logic [AW-1:0] addr0, addr1;
  logic [W-1:0]  wdata0, wdata1;
  logic          gnt0, gnt1, rvalid0, rvalid1;
  logic [W-1:0]  rdata0, rdata1;
  logic          ram_wr_ena;
  logic [AW-1:0] ram_addr;
  logic [W-1:0]  ram_wr_data;
  logic [W-1:0]  ram_rd_data;
`ifdef MEM_ARBITER_STATS_EN
  logic [31:0]   stall_count;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    logic        port;
    logic [31:0] data;
  } sb_t;
  sb_t sbq[$];

  logic [W-1:0] ram_mem [L];
  logic [W-1:0] exp_mem [L];
  logic         mem_init;

  always #5 clk = ~clk;

  mem_arbiter #(.W(W), .L(L), .MAX_BURST(4)) dut (
    .clk         (clk),
    .rst         (rst),
    .req0        (req0),
    .req1        (req1),
    .lock0       (lock0),
    .lock1       (lock1),
    .we0         (we0),
    .we1         (we1),
    .addr0       (addr0),
    .addr1       (addr1),
    .wdata0      (wdata0),
    .wdata1      (wdata1),
    .gnt0        (gnt0),
    .gnt1        (gnt1),
    .rvalid0     (rvalid0),
    .rvalid1     (rvalid1),
    .rdata0      (rdata0),
    .rdata1      (rdata1),
    .ram_wr_ena  (ram_wr_ena),
    .ram_addr    (ram_addr),
    .ram_wr_data (ram_wr_data),
    .ram_rd_data (ram_rd_data)
`ifdef MEM_ARBITER_STATS_EN
    ,
    .stall_count (stall_count)
`endif
  );

  // RAM model: asynchronous read, write at the clock edge.
  assign ram_rd_data = ram_mem[ram_addr];
  always @(posedge clk) begin
    if (mem_init) begin
      for (int i = 0; i < L; i++) ram_mem[i] <= 32'h1000_0000 + 32'(i);
    end else if (ram_wr_ena) begin
      ram_mem[ram_addr] <= ram_wr_data;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic set0(input logic r, input logic lk, input logic w,
                      input int a, input logic [31:0] d);
    req0 = r; lock0 = lk; we0 = w; addr0 = AW'(a); wdata0 = d;
  endtask

  task automatic set1(input logic r, input logic lk, input logic w,
                      input int a, input logic [31:0] d);
    req1 = r; lock1 = lk; we1 = w; addr1 = AW'(a); wdata1 = d;
  endtask

  task automatic sb_check(input string tag);
    sb_t         e;
    logic        ev0 = 1'b0;
    logic        ev1 = 1'b0;
    logic [31:0] ed0 = '0;
    logic [31:0] ed1 = '0;
    while (sbq.size() > 0) begin
      e = sbq.pop_front();
      if (e.port) begin ev1 = 1'b1; ed1 = e.data; end
      else        begin ev0 = 1'b1; ed0 = e.data; end
    end
    chk({tag, ".rvalid0"}, 32'(rvalid0), 32'(ev0));
    chk({tag, ".rvalid1"}, 32'(rvalid1), 32'(ev1));
    if (ev0) chk({tag, ".rdata0"}, rdata0, ed0);
    if (ev1) chk({tag, ".rdata1"}, rdata1, ed1);
  endtask

  // One clock cycle with the current inputs: check grant/RAM side, update
  // the expected memory and scoreboard, clock, then check read responses.
  task automatic step(input logic eg0, input logic eg1, input string tag);
    sb_t e;
    #1;
    chk({tag, ".gnt0"}, 32'(gnt0), 32'(eg0));
    chk({tag, ".gnt1"}, 32'(gnt1), 32'(eg1));
    chk({tag, ".wr_ena"}, 32'(ram_wr_ena), 32'((eg0 & we0) | (eg1 & we1)));
    chk({tag, ".addr"}, 32'(ram_addr), 32'(eg1 ? addr1 : addr0));
    if (eg0 || eg1) chk({tag, ".wdata"}, ram_wr_data, eg1 ? wdata1 : wdata0);
    if (eg0 && !we0) begin e.port = 1'b0; e.data = exp_mem[addr0]; sbq.push_back(e); end
    if (eg1 && !we1) begin e.port = 1'b1; e.data = exp_mem[addr1]; sbq.push_back(e); end
    if (eg0 && we0) exp_mem[addr0] = wdata0;
    if (eg1 && we1) exp_mem[addr1] = wdata1;
    @(posedge clk);
    #1;
    sb_check(tag);
  endtask

  initial begin
    for (int i = 0; i < L; i++) exp_mem[i] = 32'h1000_0000 + 32'(i);

    // Reset: a write presented during reset must not be accepted.
    rst = 1'b1;
    mem_init = 1'b1;
    set0(1, 0, 1, 9, 32'hCAFE_F00D);
    set1(0, 0, 0, 0, 0);
    step(0, 0, "rst_a");
    mem_init = 1'b0;
    step(0, 0, "rst_b");
    rst = 1'b0;
    set0(0, 0, 0, 0, 0);
    #1;
    chk("rst.gnt0", 32'(gnt0), 0);
    chk("rst.gnt1", 32'(gnt1), 0);
    chk("rst.wr_ena", 32'(ram_wr_ena), 0);
    chk("rst.rvalid0", 32'(rvalid0), 0);
    chk("rst.rvalid1", 32'(rvalid1), 0);
    chk("rst.rdata0", rdata0, 0);
    chk("rst.rdata1", rdata1, 0);
`ifdef MEM_ARBITER_STATS_EN
    chk("rst.stall", stall_count, 0);
`endif
    step(0, 0, "idle0");

    // Write then read-back on the following cycle.
    set0(1, 0, 1, 5, 32'hDEAD_BEEF);
    step(1, 0, "wr5");
    set0(1, 0, 0, 5, 0);
    step(1, 0, "rd5");
    set0(1, 0, 0, 9, 0);
    step(1, 0, "rd9");
    set0(0, 0, 0, 0, 0);
    step(0, 0, "idle1");

    // Round-robin with both requesting, no lock.
    set1(1, 0, 0, 3, 0);
    step(0, 1, "rr_pre");
    set0(1, 0, 0, 10, 0);
    set1(1, 0, 0, 11, 0);
    step(1, 0, "rr0");
    step(0, 1, "rr1");
    step(1, 0, "rr2");
    step(0, 1, "rr3");

    // Burst limit: requester 1 locked, requester 0 waiting.
    set1(0, 0, 0, 0, 0);
    set0(1, 0, 0, 12, 0);
    step(1, 0, "bl_pre");
    set0(1, 0, 0, 21, 0);
    for (int i = 0; i < 4; i++) begin
      set1(1, 1, 1, 20 + i, 32'hB000_0000 + 32'(i));
      step(0, 1, $sformatf("bl_own%0d", i));
    end
    set1(1, 1, 1, 24, 32'hB000_0004);
    step(1, 0, "bl_release");
    step(0, 1, "bl_regain");
    set0(0, 0, 0, 0, 0);
    set1(0, 0, 0, 0, 0);
    step(0, 0, "bl_idle");
    set1(1, 0, 0, 22, 0);
    step(0, 1, "bl_rdback");

    // Uncontested locked burst beyond MAX_BURST, then contention.
    set1(0, 0, 0, 0, 0);
    for (int i = 0; i < 10; i++) begin
      set0(1, 1, 1, 40 + i, 32'hA000_0000 + 32'(i));
      step(1, 0, $sformatf("ub%0d", i));
    end
    set0(1, 1, 0, 40, 0);
    set1(1, 0, 0, 49, 0);
    step(0, 1, "ub_steal");
    set0(0, 0, 0, 0, 0);
    set1(0, 0, 0, 0, 0);
    step(0, 0, "ub_idle");

    // Reset in the middle of a locked read burst.
    set0(1, 1, 0, 5, 0);
    step(1, 0, "mb_a");
    step(1, 0, "mb_b");
    rst = 1'b1;
    set0(1, 1, 1, 5, 32'hBAD0_BAD0);
    step(0, 0, "mb_rst");
    chk("mb_rst.rdata0", rdata0, 0);
    rst = 1'b0;
    set0(1, 0, 0, 5, 0);
    set1(1, 0, 0, 6, 0);
    step(1, 0, "mb_post");
    set0(0, 0, 0, 0, 0);
    set1(0, 0, 0, 0, 0);
    step(0, 0, "mb_idle");

`ifdef MEM_ARBITER_STATS_EN
    // Stall counter over 4 contested cycles.
    rst = 1'b1;
    step(0, 0, "st_rst");
    rst = 1'b0;
    chk("st.zero", stall_count, 0);
    set0(1, 0, 0, 1, 0);
    set1(1, 0, 0, 2, 0);
    step(1, 0, "st0");
    step(0, 1, "st1");
    step(1, 0, "st2");
    step(0, 1, "st3");
    chk("st.count", stall_count, 4);
    set0(0, 0, 0, 0, 0);
    set1(0, 0, 0, 0, 0);
    step(0, 0, "st_idle");
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
